// File: rtl/instr_decode_stage_if.sv
// Fetch-to-execute handshake bundle: input word channel and decoded output channel.
// master drives words and consumes decoded output; slave is the decode stage.
interface instr_decode_stage_if #(
  parameter int IW  = 16,
  parameter int PCW = 12
);
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_word;
  logic [PCW-1:0]  in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_op_dk;
  logic [3:0]      out_op_s;
  logic [3:0]      out_s;
  logic            out_ind;
  logic [IW-10:0]  out_k;
  logic [IW-1:0]   out_all;
  logic            out_is_long;
  logic [IW-1:0]   out_limm;
  logic [PCW-1:0]  out_pc;

  modport master (
    output in_valid, in_word, in_pc, out_ready,
    input  in_ready, out_valid, out_op_dk, out_op_s, out_s, out_ind, out_k,
           out_all, out_is_long, out_limm, out_pc
  );

  modport slave (
    input  in_valid, in_word, in_pc, out_ready,
    output in_ready, out_valid, out_op_dk, out_op_s, out_s, out_ind, out_k,
           out_all, out_is_long, out_limm, out_pc
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage: splits fields, assembles two-word long immediates.
// Latency 1 after the last word; in_ready = (!out_valid || out_ready) && !flush.
module instr_decode_stage #(
  parameter int         IW         = 16,
  parameter int         PCW        = 12,
  parameter logic [7:0] LONG_MASK  = 8'hF0,
  parameter logic [7:0] LONG_MATCH = 8'hF0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  instr_decode_stage_if.slave  bus
);
  localparam int KW = IW - 9;

  typedef enum logic {FIRST, EXT} state_t;

  state_t          state_q;
  logic            out_valid_q;
  logic [IW-1:0]   out_all_q;
  logic [IW-1:0]   out_limm_q;
  logic [PCW-1:0]  out_pc_q;
  logic            out_is_long_q;
  logic [IW-1:0]   hold_word_q;
  logic [PCW-1:0]  hold_pc_q;

  logic in_ready;
  logic accept;
  logic drain;
  logic word_is_long;

  assign in_ready     = (!out_valid_q || bus.out_ready) && !flush;
  assign accept       = bus.in_valid && in_ready;
  assign drain        = out_valid_q && bus.out_ready;
  assign word_is_long = ((bus.in_word[IW-1 -: 8] & LONG_MASK) == LONG_MATCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FIRST;
      out_valid_q   <= 1'b0;
      out_all_q     <= '0;
      out_limm_q    <= '0;
      out_pc_q      <= '0;
      out_is_long_q <= 1'b0;
      hold_word_q   <= '0;
      hold_pc_q     <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      state_q     <= FIRST;
    end else begin
      if (drain) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          FIRST: begin
            if (word_is_long) begin
              hold_word_q <= bus.in_word;
              hold_pc_q   <= bus.in_pc;
              state_q     <= EXT;
            end else begin
              out_all_q     <= bus.in_word;
              out_limm_q    <= '0;
              out_pc_q      <= bus.in_pc;
              out_is_long_q <= 1'b0;
              out_valid_q   <= 1'b1;
            end
          end
          EXT: begin
            // Second word is raw immediate data; never opcode-decoded.
            out_all_q     <= hold_word_q;
            out_limm_q    <= bus.in_word;
            out_pc_q      <= hold_pc_q;
            out_is_long_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= FIRST;
          end
          default: state_q <= FIRST;
        endcase
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_all     = out_all_q;
  assign bus.out_op_dk   = out_all_q[IW-1 -: 8];
  assign bus.out_op_s    = out_all_q[IW-1 -: 4];
  assign bus.out_s       = out_all_q[IW-5 -: 4];
  assign bus.out_ind     = out_all_q[KW];
  assign bus.out_k       = out_all_q[KW-1:0];
  assign bus.out_is_long = out_is_long_q;
  assign bus.out_limm    = out_limm_q;
  assign bus.out_pc      = out_pc_q;
endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
Registered, parametrised successor to the combinational instruction field splitter. It sits between instruction fetch and execute and accepts instruction words over a valid/ready handshake. It recognises two-word instructions and assembles the second word as a full-width long immediate. It presents all decoded fields, the long immediate and the PC from a single output register, with back-pressure and flush.

Parameters:
IW, 16, instruction word width; must be >= 16; KW = IW-9 is a derived local constant (short field width).
PCW, 12, program-counter width carried alongside each instruction.
LONG_MASK, 8'hF0, mask applied to the 8-bit major opcode to detect two-word instructions.
LONG_MATCH, 8'hF0, instruction is two-word when (op_dk & LONG_MASK) == LONG_MATCH.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous discard of in-flight state and output.
in_valid  input  1  instruction word presented.
in_ready  output  1  stage can accept a word this cycle.
in_word  input  IW  instruction word.
in_pc  input  PCW  address of in_word.
out_valid  output  1  decoded instruction held in the output register.
out_ready  input  1  consumer accepts the output this cycle.
out_op_dk  output  8  in_word[IW-1:IW-8] of the first word.
out_op_s  output  4  in_word[IW-1:IW-4] of the first word.
out_s  output  4  in_word[IW-5:IW-8] of the first word.
out_ind  output  1  in_word[KW] of the first word (indirect/ARP bit).
out_k  output  KW  in_word[KW-1:0] of the first word (direct address or short immediate).
out_all  output  IW  full first word.
out_is_long  output  1  instruction was two-word.
out_limm  output  IW  second word; 0 when out_is_long=0.
out_pc  output  PCW  PC of the first word.

Behaviour:
- Reset (asynchronous, active-high): state=FIRST; out_valid=0; every out_* data port=0. Hold registers=0.
- Input acceptance: in_ready = (!out_valid || out_ready) && !flush. A word is accepted when in_valid && in_ready.
- Output transfer: completes when out_valid && out_ready. out_valid falls next cycle unless a new instruction completes in the same cycle. Output data is stable while out_valid && !out_ready.
- State FIRST, word accepted, not long: the output register loads all fields from the word, out_is_long=0, out_limm=0, out_pc=in_pc. out_valid=1 next cycle (latency 1).
- State FIRST, word accepted, long: the word and in_pc go into the hold registers; state moves to EXT; the output register is unchanged. A pending output may still drain in this cycle.
- State EXT, word accepted: the output loads fields from the held first word, out_limm=in_word, out_is_long=1, out_pc=held PC. State moves to FIRST and out_valid=1 next cycle. The second word is never opcode-decoded, even if it matches LONG_MATCH.
- Simultaneous transfer and accept: a back-to-back short stream sustains 1 instruction/cycle with out_valid held high. A long instruction sustains 1 per 2 cycles.
- No accept in EXT: the stage waits indefinitely holding the first word; out_valid keeps its own value.
- flush=1 has priority over everything: next cycle out_valid=0 and state=FIRST. in_ready=0 during the flush cycle, so no word is accepted. Data ports keep their old values (don't-care while out_valid=0).
- reset asserted mid-instruction, including in EXT, discards the held word immediately.
- Field extraction is purely positional from IW; no sign extension is performed on out_k or out_limm.

Test Plan:
- Reset then a single short word 16'h2A85 at pc=12'h010, out_ready=1 -> one cycle later out_valid=1, op_dk=8'h2A, op_s=4'h2, s=4'hA, ind=1, k=7'h05, is_long=0, limm=0, pc=12'h010.
- Long pair 16'hF312 (pc=12'h020) then 16'hBEEF -> no output after the first word; one cycle after the second word, op_dk=8'hF3, is_long=1, limm=16'hBEEF, pc=12'h020.
- Back-pressure: out_ready=0 while three short words are offered -> first held stable, in_ready=0, remaining words not accepted. Raising out_ready drains them in order, one per cycle.
- Second word equals 16'hF0F0 -> treated as immediate: is_long=1, limm=16'hF0F0, and the stage returns to FIRST.
- flush asserted in EXT after 16'hF100 -> out_valid=0 next cycle. The next word 16'h1234 decodes as short with op_dk=8'h12.
- Async reset pulse mid-cycle while out_valid=1 in EXT -> out_valid=0 and outputs=0 immediately. The next short word decodes correctly with latency 1.
